addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
- Multi-byte add/subtract sequencer that sits directly upstream of the 8-bit add/sub stage.
- Latches NBYTES-wide operands and presents them to the stage one byte at a time, LSB first, through the stage's a/b/isSub/isCarry/cin inputs.
- After a fixed settle time per byte, it captures the stage's q/cout, chains cout into the next byte, and assembles the wide result and final carry.
- Gives the 8-bit datapath 16/32-bit arithmetic without widening the adder.

Parameters:
NBYTES, 4, number of bytes per operand (>=1); operand width = 8*NBYTES
SETTLE, 3, clock cycles each byte is held before capture (>=1); must satisfy SETTLE*Tclk >= 238 ns worst-case stage latency

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request an operation; sampled only in IDLE
op_sub  input  1  0 = add, 1 = subtract
op_carry  input  1  1 = use carry_in on byte 0 (ADC/SBC); 0 = plain add/sub
carry_in  input  1  incoming carry for byte 0 when op_carry=1
opa  input  8*NBYTES  operand A
opb  input  8*NBYTES  operand B
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: result and carry_out valid
result  output  8*NBYTES  wide result, held until the next accepted start
carry_out  output  1  final byte cout (for subtract: 1 = no borrow)
as_a  output  8  to add/sub stage a
as_b  output  8  to add/sub stage b
as_isSub  output  1  to add/sub stage isSub
as_isCarry  output  1  to add/sub stage isCarry
as_cin  output  1  to add/sub stage cin
as_q  input  8  from add/sub stage q
as_cout  input  1  from add/sub stage cout

Behaviour:
- States: IDLE, RUN, DONE. Registers: latched opa/opb/op_sub/op_carry/carry_in, byte index idx, settle counter cnt, chain carry cc, result, carry_out.
- Reset (rst_n low, asynchronous): state=IDLE; all latched operands, idx, cnt, cc, result and carry_out cleared to 0; busy=0; done=0. All as_* outputs are therefore 0.
- IDLE:
  - If start=1 at a clock edge: latch all operand inputs, idx=0, cnt=0, go to RUN.
  - Otherwise hold. result and carry_out retain their previous values.
- RUN:
  - busy=1.
  - as_a / as_b = latched opa / opb byte idx.
  - as_isSub = latched op_sub.
  - Byte 0: as_isCarry = latched op_carry; as_cin = latched carry_in.
  - Byte idx>0: as_isCarry=1; as_cin=cc.
  - Each edge with cnt<SETTLE-1: cnt++.
  - Edge with cnt==SETTLE-1:
    - result byte idx = as_q; cc = as_cout; cnt = 0.
    - If idx==NBYTES-1: carry_out = as_cout and go to DONE.
    - Otherwise idx++.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE. idx stays at NBYTES-1 until the next start.
- as_* are driven combinationally from registers only and are stable for the whole settle window of each byte.
- Outside RUN, as_* reflect the latched operands at the current idx; the stage output is not captured.
- Latency: start sampled at edge t; byte i captured at edge t+(i+1)*SETTLE; done high during the cycle following edge t+NBYTES*SETTLE. Defaults: done 12 cycles after start, high for 1 cycle.
- Arithmetic:
  - result = opa + opb + (op_carry ? carry_in : 0), modulo 2^(8*NBYTES).
  - Subtract: result = opa - opb - (op_carry ? ~carry_in : 0), i.e. the 6502-style borrow convention propagated per byte.
  - carry_out is the final-byte cout.
- start while busy or in DONE is ignored; no queuing. Inputs other than start are don't-care outside the IDLE start edge.
- rst_n asserted mid-RUN aborts immediately; the partial result is discarded and cleared to 0.
- NBYTES=1 degenerates to a single capture; SETTLE=1 captures on every edge.

Test Plan (NBYTES=4, SETTLE=3, stage modelled with up to 2 cycles delay):
- Reset:
  - Assert rst_n low mid-RUN -> busy, done, result, carry_out and as_* all 0 without a clock edge.
  - Release reset, start 0x12345678 + 0x11111111 -> result 0x23456789, carry_out 0.
- Add with ripple:
  - 0x00FFFFFF + 0x00000001, op_carry=0 -> result 0x01000000, carry_out 0.
  - done pulses exactly 12 cycles after the start edge, for 1 cycle.
  - as_isCarry=0 on byte 0 and 1 on bytes 1-3.
- Add overflow with carry: 0xFFFFFFFF + 0x00000000, op_carry=1, carry_in=1 -> result 0x00000000, carry_out 1.
- Subtract:
  - 0x00000000 - 0x00000001 -> 0xFFFFFFFF, carry_out 0.
  - 5 - 3 -> 0x00000002, carry_out 1.
  - 10 - 3 with op_carry=1, carry_in=0 -> 0x00000006.
- Busy collision:
  - Start 1+1, then pulse start with 7+7 on cycle 4 -> second start ignored; result 0x00000002, a single done pulse.
  - result is unchanged afterwards until a new start is accepted in IDLE.
- Settle check: hold as_q garbage until 2 cycles after each byte is presented -> result remains correct, and as_a/as_b are stable across each 3-cycle window.

Source files
------------

// File: rtl/addsub_seq_if.sv
// Bundle between the multi-byte add/sub sequencer and its two neighbours:
// the requesting client (start/operands/result) and the 8-bit add/sub stage (as_*).
interface addsub_seq_if #(
    parameter int NBYTES = 4
);
    logic                  start;
    logic                  op_sub;
    logic                  op_carry;
    logic                  carry_in;
    logic [8*NBYTES-1:0]   opa;
    logic [8*NBYTES-1:0]   opb;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   result;
    logic                  carry_out;
    logic [7:0]            as_a;
    logic [7:0]            as_b;
    logic                  as_isSub;
    logic                  as_isCarry;
    logic                  as_cin;
    logic [7:0]            as_q;
    logic                  as_cout;

    // start is a request with no ready: it is taken only when busy=0 and done=0,
    // and done is a single-cycle valid for result/carry_out with no back-pressure.
    modport slave (
        input  start, op_sub, op_carry, carry_in, opa, opb, as_q, as_cout,
        output busy, done, result, carry_out, as_a, as_b, as_isSub, as_isCarry, as_cin
    );

    modport master (
        output start, op_sub, op_carry, carry_in, opa, opb, as_q, as_cout,
        input  busy, done, result, carry_out, as_a, as_b, as_isSub, as_isCarry, as_cin
    );
endinterface

// File: rtl/addsub_seq.sv
// Feeds wide operands through an external 8-bit add/sub stage one byte at a time,
// LSB first, chaining the stage carry and assembling the wide result.
module addsub_seq #(
    parameter int NBYTES = 4,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_seq_if.slave       bus,
    output logic [1:0]        dbg_state
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;

    logic [NBYTES-1:0][7:0]  a_r;
    logic [NBYTES-1:0][7:0]  b_r;
    logic [NBYTES-1:0][7:0]  res_r;
    logic                    sub_r;
    logic                    carry_r;
    logic                    cin_r;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic                    cc;
    logic                    cout_r;
    logic                    last_tick;
    logic                    last_byte;

    assign last_tick = (cnt == CW'(SETTLE - 1));
    assign last_byte = (idx == IW'(NBYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_RUN;
            S_RUN:   if (last_tick && last_byte) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Stage inputs come only from registers so they hold still across each settle window.
    always_comb begin
        bus.busy       = (state == S_RUN);
        bus.done       = (state == S_DONE);
        bus.as_a       = a_r[idx];
        bus.as_b       = b_r[idx];
        bus.as_isSub   = sub_r;
        bus.as_isCarry = (idx == '0) ? carry_r : 1'b1;
        bus.as_cin     = (idx == '0) ? cin_r : cc;
        bus.result     = res_r;
        bus.carry_out  = cout_r;
        dbg_state      = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            cin_r   <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            cc      <= 1'b0;
            res_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.opa;
                        b_r     <= bus.opb;
                        sub_r   <= bus.op_sub;
                        carry_r <= bus.op_carry;
                        cin_r   <= bus.carry_in;
                        idx     <= '0;
                        cnt     <= '0;
                    end
                end
                S_RUN: begin
                    if (last_tick) begin
                        res_r[idx] <= bus.as_q;
                        cc         <= bus.as_cout;
                        cnt        <= '0;
                        if (last_byte) cout_r <= bus.as_cout;
                        else           idx    <= idx + IW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: a slow 8-bit add/sub stage model that outputs junk until its
// inputs have been stable for 2 cycles, plus directed and random wide operations.
module tb_addsub_seq;
    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;
    int          n_cmp;
    int          n_bad;
    logic [32:0] exp_q[$];

    addsub_seq_if #(.NBYTES(4)) bus ();

    addsub_seq #(.NBYTES(4), .SETTLE(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage model: inputs must stay unchanged for 2 cycles before q/cout are meaningful.
    logic [18:0] snap;
    int          age;
    logic [7:0]  junk_q;
    logic        junk_c;
    logic [8:0]  s9;

    initial begin
        snap   = '0;
        age    = 0;
        junk_q = 8'h5a;
        junk_c = 1'b1;
    end

    always @(negedge clk) begin
        if ({bus.as_a, bus.as_b, bus.as_isSub, bus.as_isCarry, bus.as_cin} !== snap) begin
            snap <= {bus.as_a, bus.as_b, bus.as_isSub, bus.as_isCarry, bus.as_cin};
            age  <= 0;
        end else if (age < 100) begin
            age <= age + 1;
        end
        junk_q <= 8'($urandom_range(0, 255));
        junk_c <= 1'($urandom_range(0, 1));
    end

    always_comb begin
        if (bus.as_isSub)
            s9 = {1'b0, bus.as_a} + {1'b0, ~bus.as_b} + {8'd0, (bus.as_isCarry ? bus.as_cin : 1'b1)};
        else
            s9 = {1'b0, bus.as_a} + {1'b0, bus.as_b} + {8'd0, (bus.as_isCarry & bus.as_cin)};
        if (age >= 2) begin
            bus.as_q    = s9[7:0];
            bus.as_cout = s9[8];
        end else begin
            bus.as_q    = junk_q;
            bus.as_cout = junk_c;
        end
    end

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic c, input logic ci);
        logic [32:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + 33'(c ? ci : 1'b1);
        else   r = {1'b0, a} + {1'b0, b} + 33'(c & ci);
        return r;
    endfunction

    // Driver: one-cycle start pulse; returns at the negedge right after the start edge.
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic c, input logic ci);
        @(negedge clk);
        bus.opa      = a;
        bus.opb      = b;
        bus.op_sub   = s;
        bus.op_carry = c;
        bus.carry_in = ci;
        bus.start    = 1'b1;
        exp_q.push_back(model(a, b, s, c, ci));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.opa      = $urandom;
        bus.opb      = $urandom;
        bus.op_sub   = 1'($urandom_range(0, 1));
        bus.op_carry = 1'($urandom_range(0, 1));
        bus.carry_in = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 40 && !ok) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int          cyc;
        bit          ok;
        logic [32:0] exp;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.as_a, bus.as_b,
             bus.as_isSub, bus.as_isCarry, bus.as_cin} !== '0) begin
            n_bad++;
            $display("FAIL reset_initial busy=%b done=%b result=%h cout=%b as_a=%h as_b=%h required all 0",
                     bus.busy, bus.done, bus.result, bus.carry_out, bus.as_a, bus.as_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_busy busy=%b required 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.as_a, bus.as_b,
             bus.as_isSub, bus.as_isCarry, bus.as_cin} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_run busy=%b done=%b result=%h cout=%b as_a=%h as_b=%h required all 0",
                     bus.busy, bus.done, bus.result, bus.carry_out, bus.as_a, bus.as_b);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0);
        wait_done(cyc, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!ok || {bus.carry_out, bus.result} !== exp) begin
            n_bad++;
            $display("FAIL reset_after_op done=%b cout/result=%h required %h", ok, {bus.carry_out, bus.result}, exp);
        end
    endtask

    task automatic test_add_ripple();
        int          cyc;
        bit          got;
        logic [32:0] exp;
        drive_op(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        cyc = 0;
        got = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc < 12 && cyc % 3 == 1) begin
                n_cmp++;
                if (bus.as_isCarry !== (cyc / 3 != 0)) begin
                    n_bad++;
                    $display("FAIL ripple_iscarry byte=%0d as_isCarry=%b required %b",
                             cyc / 3, bus.as_isCarry, (cyc / 3 != 0));
                end
            end
            if (bus.done === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got || cyc != 12) begin
            n_bad++;
            $display("FAIL ripple_latency done_seen=%b cycles=%0d required 12", got, cyc);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if ({bus.carry_out, bus.result} !== exp) begin
            n_bad++;
            $display("FAIL ripple_result cout/result=%h required %h", {bus.carry_out, bus.result}, exp);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL ripple_done_width done=%b required 0 one cycle later", bus.done);
        end
    endtask

    task automatic test_arith();
        logic [31:0] ta[4] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000005, 32'h0000000A};
        logic [31:0] tb[4] = '{32'h00000000, 32'h00000001, 32'h00000003, 32'h00000003};
        logic        ts[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic        tc[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        ti[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [32:0] fixed[4] = '{33'h1_00000000, 33'h0_FFFFFFFF, 33'h1_00000002, 33'h1_00000006};
        int          cyc;
        bit          ok;
        logic [32:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive_op(ta[i], tb[i], ts[i], tc[i], ti[i]);
            wait_done(cyc, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || {bus.carry_out, bus.result} !== exp || exp !== fixed[i]) begin
                n_bad++;
                $display("FAIL arith_%0d done=%b cout/result=%h required %h", i, ok,
                         {bus.carry_out, bus.result}, fixed[i]);
            end
        end
    endtask

    task automatic test_busy_collision();
        int          dones;
        logic [32:0] exp;
        drive_op(32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.opa   = 32'd7;
        bus.opb   = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        exp   = exp_q.pop_front();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                n_cmp++;
                if ({bus.carry_out, bus.result} !== exp) begin
                    n_bad++;
                    $display("FAIL collision_result cout/result=%h required %h", {bus.carry_out, bus.result}, exp);
                end
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_bad++;
            $display("FAIL collision_done_count dones=%0d required 1", dones);
        end
        n_cmp++;
        if ({bus.busy, bus.carry_out, bus.result} !== {1'b0, exp}) begin
            n_bad++;
            $display("FAIL collision_hold busy=%b cout/result=%h required 0/%h", bus.busy,
                     {bus.carry_out, bus.result}, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        c;
        logic        ci;
        int          cyc;
        bit          got;
        logic [32:0] exp;
        for (int n = 0; n < 6; n++) begin
            a  = $urandom;
            b  = $urandom;
            s  = 1'($urandom_range(0, 1));
            c  = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            drive_op(a, b, s, c, ci);
            cyc = 0;
            got = 1'b0;
            while (cyc < 40 && !got) begin
                @(negedge clk);
                cyc++;
                if (cyc < 12) begin
                    n_cmp++;
                    if (bus.as_a !== a[8*(cyc/3) +: 8] || bus.as_b !== b[8*(cyc/3) +: 8]) begin
                        n_bad++;
                        $display("FAIL b2b_stable op=%0d cyc=%0d as_a=%h as_b=%h required %h %h", n, cyc,
                                 bus.as_a, bus.as_b, a[8*(cyc/3) +: 8], b[8*(cyc/3) +: 8]);
                    end
                end
                if (bus.done === 1'b1) got = 1'b1;
            end
            exp = exp_q.pop_front();
            n_cmp++;
            if (!got || {bus.carry_out, bus.result} !== exp) begin
                n_bad++;
                $display("FAIL b2b_result op=%0d done=%b cout/result=%h required %h", n, got,
                         {bus.carry_out, bus.result}, exp);
            end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op_sub   = 1'b0;
        bus.op_carry = 1'b0;
        bus.carry_in = 1'b0;
        bus.opa      = '0;
        bus.opb      = '0;
        test_reset();
        test_add_ripple();
        test_arith();
        test_busy_collision();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
